// File: rtl/line_clear_ctrl.sv
// Line-clear sequencer: scans the board for full rows, then repeatedly removes the
// bottom-most full row by shifting everything above it down one row.
module line_clear_ctrl #(
    parameter int ROWS   = 20,
    parameter int COLS   = 10,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] lines_cleared,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [COLS-1:0]   mem_rd_data,
    output logic              mem_wr_en,
    output logic [COLS-1:0]   mem_wr_data
);

    // state     | meaning
    // IDLE      | waiting for start
    // SCAN      | read every row, build full-row mask (ROWS+1 cycles)
    // PICK      | choose bottom-most full row k, or finish
    // SHIFT_RD  | source read for row r (row r-1)
    // SHIFT_WR  | row r receives row r-1, r decrements
    // CLEAR_TOP | row 0 blanked, mask shifted down, count bumped
    // DONE      | one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE, SCAN, PICK, SHIFT_RD, SHIFT_WR, CLEAR_TOP, DONE
    } state_t;

    localparam logic [ADDR_W:0]   SCAN_END = (ADDR_W+1)'(ROWS);
    localparam logic [ADDR_W:0]   LAST_RD  = (ADDR_W+1)'(ROWS - 1);
    localparam logic [ROWS-1:0]   ONE      = ROWS'(1);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   cnt;
    logic [ROWS-1:0]   mask;
    logic [ADDR_W-1:0] k, r, hi_idx, scan_row;
    logic              rd_vld;
    logic              rd_nxt, wr_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [COLS-1:0]   wdata_nxt;

    assign scan_row = cnt[ADDR_W-1:0] - ADDR_W'(1);

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < ROWS; i++)
            if (mask[i]) hi_idx = ADDR_W'(i);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start) state_nxt = SCAN;
            SCAN:      if (cnt == SCAN_END) state_nxt = PICK;
            PICK: begin
                if (mask == '0)        state_nxt = DONE;
                else if (hi_idx != '0) state_nxt = SHIFT_RD;
                else                   state_nxt = CLEAR_TOP;
            end
            SHIFT_RD:  state_nxt = SHIFT_WR;
            SHIFT_WR:  state_nxt = (r > ADDR_W'(1)) ? SHIFT_RD : CLEAR_TOP;
            CLEAR_TOP: state_nxt = PICK;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // RAM strobes are issued one cycle ahead. The shift is software-pipelined: the
    // read for the next source row rides in SHIFT_WR, and the write of row r lands
    // in the following cycle, so the write data is always a registered copy.
    always_comb begin
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wr_data;
        if (rd_vld && (state == SHIFT_RD || state == SHIFT_WR))
            wdata_nxt = mem_rd_data;
        case (state)
            IDLE: if (start) begin
                rd_nxt   = 1'b1;
                addr_nxt = '0;
            end
            SCAN: if (cnt < LAST_RD) begin
                rd_nxt   = 1'b1;
                addr_nxt = cnt[ADDR_W-1:0] + ADDR_W'(1);
            end
            PICK: if (mask != '0) begin
                if (hi_idx != '0) begin
                    rd_nxt   = 1'b1;
                    addr_nxt = hi_idx - ADDR_W'(1);
                end else begin
                    wr_nxt    = 1'b1;
                    addr_nxt  = '0;
                    wdata_nxt = '0;
                end
            end
            SHIFT_RD: if (r > ADDR_W'(1)) begin
                rd_nxt   = 1'b1;
                addr_nxt = r - ADDR_W'(2);
            end
            SHIFT_WR: begin
                wr_nxt   = 1'b1;
                addr_nxt = r;
            end
            CLEAR_TOP: if (k != '0) begin
                wr_nxt    = 1'b1;
                addr_nxt  = '0;
                wdata_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            rd_vld      <= 1'b0;
        end else begin
            busy        <= (state_nxt != IDLE);
            done        <= (state_nxt == DONE);
            mem_rd_en   <= rd_nxt;
            mem_wr_en   <= wr_nxt;
            mem_addr    <= addr_nxt;
            mem_wr_data <= wdata_nxt;
            rd_vld      <= mem_rd_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            mask          <= '0;
            k             <= '0;
            r             <= '0;
            lines_cleared <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    cnt           <= '0;
                    mask          <= '0;
                    lines_cleared <= '0;
                end
                SCAN: begin
                    cnt <= cnt + (ADDR_W+1)'(1);
                    if (cnt != '0) mask[scan_row] <= &mem_rd_data;
                end
                PICK: begin
                    k <= hi_idx;
                    r <= hi_idx;
                end
                SHIFT_WR: r <= r - ADDR_W'(1);
                CLEAR_TOP: begin
                    mask          <= (mask & ~(ONE << k)) << 1;
                    lines_cleared <= lines_cleared + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a behavioural 1-cycle-latency board RAM.
module tb_line_clear_ctrl;
    localparam int ROWS = 20, COLS = 10, ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset, start;
    logic              busy, done, mem_rd_en, mem_wr_en;
    logic [ADDR_W-1:0] lines_cleared, mem_addr;
    logic [COLS-1:0]   mem_rd_data, mem_wr_data;

    logic [COLS-1:0]   ram [ROWS];
    logic [COLS-1:0]   init_img [ROWS];
    logic [COLS-1:0]   exp_img [ROWS];
    logic              ld_en = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic [COLS-1:0]   ld_data = '0;
    int                wr_total = 0, overlap_total = 0;
    int                errors = 0, checks = 0;

    always #5 clk = ~clk;

    line_clear_ctrl #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .lines_cleared(lines_cleared), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
    );

    always @(posedge clk) begin
        if (ld_en)          ram[ld_addr] <= ld_data;
        else if (mem_wr_en) ram[mem_addr] <= mem_wr_data;
        if (mem_rd_en)      mem_rd_data <= ram[mem_addr];
        if (mem_wr_en)      wr_total <= wr_total + 1;
        if (mem_wr_en && mem_rd_en) overlap_total <= overlap_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_imgs();
        for (int i = 0; i < ROWS; i++) begin
            init_img[i] = '0;
            exp_img[i]  = '0;
        end
    endtask

    task automatic load_board();
        for (int i = 0; i < ROWS; i++) begin
            @(negedge clk);
            ld_en   = 1'b1;
            ld_addr = ADDR_W'(i);
            ld_data = init_img[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_image(input string tag);
        for (int i = 0; i < ROWS; i++)
            check($sformatf("%s_row%0d", tag, i), 32'(ram[i]), 32'(exp_img[i]));
    endtask

    // cyc = cycles from busy rising to done observed high
    task automatic run_pass(input bit hold, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        @(negedge clk);
        check("done_pulse_end", 32'(done), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
    endtask

    int cyc, w0, o0, dcount;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", 32'(mem_wr_data), 32'd0);
        check("rst_lines", 32'(lines_cleared), 32'd0);
        reset = 1'b0;

        // empty board
        clear_imgs();
        load_board();
        w0 = wr_total;
        run_pass(1'b0, cyc);
        check("t1_cycles", 32'(cyc), 32'd22);
        check("t1_lines", 32'(lines_cleared), 32'd0);
        check("t1_writes", 32'(wr_total - w0), 32'd0);

        // bottom row full with a partial row above it
        clear_imgs();
        init_img[19] = 10'h3FF; init_img[18] = 10'h155;
        exp_img[19]  = 10'h155;
        load_board();
        w0 = wr_total; o0 = overlap_total;
        run_pass(1'b0, cyc);
        check("t2_cycles", 32'(cyc), 32'd62);
        check("t2_lines", 32'(lines_cleared), 32'd1);
        check("t2_writes", 32'(wr_total - w0), 32'd20);
        check("t2_overlap", 32'(overlap_total - o0), 32'd0);
        check_image("t2");

        // only the top row full
        clear_imgs();
        init_img[0] = 10'h3FF;
        load_board();
        w0 = wr_total;
        run_pass(1'b0, cyc);
        check("t3_cycles", 32'(cyc), 32'd24);
        check("t3_lines", 32'(lines_cleared), 32'd1);
        check("t3_writes", 32'(wr_total - w0), 32'd1);
        check("t3_row0", 32'(ram[0]), 32'd0);

        // four adjacent full rows at the bottom
        clear_imgs();
        for (int i = 16; i < 20; i++) init_img[i] = 10'h3FF;
        init_img[15] = 10'h001;
        exp_img[19]  = 10'h001;
        load_board();
        w0 = wr_total; o0 = overlap_total;
        run_pass(1'b0, cyc);
        check("t4_cycles", 32'(cyc), 32'd182);
        check("t4_lines", 32'(lines_cleared), 32'd4);
        check("t4_writes", 32'(wr_total - w0), 32'd80);
        check("t4_overlap", 32'(overlap_total - o0), 32'd0);
        check_image("t4");

        // non-adjacent full rows
        clear_imgs();
        init_img[19] = 10'h3FF; init_img[17] = 10'h3FF; init_img[18] = 10'h3F0;
        exp_img[19]  = 10'h3F0;
        load_board();
        w0 = wr_total;
        run_pass(1'b0, cyc);
        check("t5_cycles", 32'(cyc), 32'd100);
        check("t5_lines", 32'(lines_cleared), 32'd2);
        check("t5_writes", 32'(wr_total - w0), 32'd39);
        check_image("t5");

        // reset during the second clear's SHIFT_WR (cycle 63 after busy rises)
        clear_imgs();
        init_img[19] = 10'h3FF; init_img[18] = 10'h3FF;
        load_board();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (63) @(negedge clk);
        check("t6_lines_before", 32'(lines_cleared), 32'd1);
        check("t6_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_lines", 32'(lines_cleared), 32'd0);
        check("t6_wr_en", 32'(mem_wr_en), 32'd0);
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        check("t6_quiet_after_reset", 32'(dcount), 32'd0);

        // start held high for the whole pass does not restart it
        clear_imgs();
        load_board();
        run_pass(1'b1, cyc);
        check("t6_held_cycles", 32'(cyc), 32'd22);
        check("t6_held_lines", 32'(lines_cleared), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
